// File: rtl/composite_timing_gen.sv
// Composite-video timing generator: h/v counters, region decode and
// a registered DAC level with saturating luma add.
module composite_timing_gen #(
    parameter int DAC_WIDTH       = 4,
    parameter int CLKS_PER_LINE   = 762,
    parameter int H_SYNC_CLKS     = 56,
    parameter int H_BACK_CLKS     = 58,
    parameter int H_ACTIVE_CLKS   = 640,
    parameter int LINES_PER_FIELD = 262,
    parameter int V_SYNC_LINES    = 3,
    parameter int V_ACTIVE_START  = 20,
    parameter int V_ACTIVE_LINES  = 240,
    parameter int INTERLACE       = 0,
    parameter int SYNC_LEVEL      = 0,
    parameter int BLANK_LEVEL     = 4,
    parameter int BLACK_LEVEL     = 5,
    localparam int HW = $clog2(CLKS_PER_LINE),
    localparam int VW = $clog2(LINES_PER_FIELD + 1)
) (
    input  logic                 clk,
    input  logic                 NRST,
    input  logic                 en,
    input  logic [DAC_WIDTH-1:0] pix_data,
    output logic                 pix_req,
    output logic [HW-1:0]        hcount,
    output logic [VW-1:0]        vcount,
    output logic                 field,
    output logic                 line_start,
    output logic                 field_start,
    output logic [DAC_WIDTH-1:0] composite
);

    localparam logic [HW-1:0] H_LAST = HW'(CLKS_PER_LINE - 1);
    // One extra bit so window ends equal to a power of two do not wrap
    localparam logic [HW:0] H_VS_END = (HW+1)'(CLKS_PER_LINE - H_SYNC_CLKS);
    localparam logic [HW:0] H_SY_END = (HW+1)'(H_SYNC_CLKS);
    localparam logic [HW:0] H_AC_BEG = (HW+1)'(H_SYNC_CLKS + H_BACK_CLKS);
    localparam logic [HW:0] H_AC_END =
        (HW+1)'(H_SYNC_CLKS + H_BACK_CLKS + H_ACTIVE_CLKS);

    localparam logic [VW:0] V_SY_END = (VW+1)'(V_SYNC_LINES);
    localparam logic [VW:0] V_AC_BEG = (VW+1)'(V_ACTIVE_START);
    localparam logic [VW:0] V_AC_END = (VW+1)'(V_ACTIVE_START + V_ACTIVE_LINES);
    localparam logic [VW-1:0] V_LAST0 = VW'(LINES_PER_FIELD - 1);
    localparam logic [VW-1:0] V_LAST1 = VW'(LINES_PER_FIELD);

    localparam logic [DAC_WIDTH-1:0] SYNC_C  = DAC_WIDTH'(SYNC_LEVEL);
    localparam logic [DAC_WIDTH-1:0] BLANK_C = DAC_WIDTH'(BLANK_LEVEL);
    localparam logic [DAC_WIDTH:0]   BLACK_C = (DAC_WIDTH+1)'(BLACK_LEVEL);

    typedef enum logic [1:0] {
        R_VSYNC,
        R_HSYNC,
        R_ACTIVE,
        R_BLANK
    } region_t;

    region_t              region;
    logic [HW:0]          h_ext;
    logic [VW:0]          v_ext;
    logic                 h_last;
    logic                 v_last;
    logic                 v_act;
    logic                 h_act;
    logic [DAC_WIDTH:0]   luma_sum;
    logic [DAC_WIDTH-1:0] luma_sat;
    logic [DAC_WIDTH-1:0] level;

    assign h_ext  = {1'b0, hcount};
    assign v_ext  = {1'b0, vcount};
    assign h_last = (hcount == H_LAST);
    assign v_last = (vcount == (field ? V_LAST1 : V_LAST0));
    assign v_act  = (v_ext >= V_AC_BEG) && (v_ext < V_AC_END);
    assign h_act  = (h_ext >= H_AC_BEG) && (h_ext < H_AC_END);

    always_comb begin
        region = R_BLANK;
        if (v_ext < V_SY_END)
            region = R_VSYNC;
        else if (h_ext < H_SY_END)
            region = R_HSYNC;
        else if (v_act && h_act)
            region = R_ACTIVE;
    end

    assign luma_sum = {1'b0, pix_data} + BLACK_C;
    assign luma_sat = luma_sum[DAC_WIDTH] ? '1 : luma_sum[DAC_WIDTH-1:0];

    always_comb begin
        level = BLANK_C;
        unique case (region)
            R_VSYNC:  level = (h_ext < H_VS_END) ? SYNC_C : BLANK_C;
            R_HSYNC:  level = SYNC_C;
            R_ACTIVE: level = luma_sat;
            R_BLANK:  level = BLANK_C;
            default:  level = BLANK_C;
        endcase
    end

    // NRST in the gate keeps the strobes low for the whole reset window
    assign pix_req     = NRST && en && (region == R_ACTIVE);
    assign line_start  = NRST && en && (hcount == '0);
    assign field_start = NRST && en && (hcount == '0) && (vcount == '0);

    always_ff @(posedge clk or negedge NRST) begin
        if (!NRST) begin
            hcount    <= '0;
            vcount    <= '0;
            field     <= 1'b0;
            composite <= BLANK_C;
        end else if (en) begin
            composite <= level;
            if (h_last) begin
                hcount <= '0;
                if (v_last) begin
                    vcount <= '0;
                    field  <= (INTERLACE != 0) ? ~field : 1'b0;
                end else begin
                    vcount <= vcount + 1'b1;
                end
            end else begin
                hcount <= hcount + 1'b1;
            end
        end else begin
            composite <= BLANK_C;
        end
    end

endmodule

// File: tb/tb_composite_timing_gen.sv
// Bench for composite_timing_gen: progressive and interlaced instances
// checked against a position-from-clock-count reference model.
module tb_composite_timing_gen;

    logic       clk = 1'b0;
    logic       NRST = 1'b0;
    logic       en = 1'b1;
    logic [3:0] pix_data = 4'd0;

    logic [4:0] hc   [2];
    logic [3:0] vc   [2];
    logic       fld  [2];
    logic       pr   [2];
    logic       ls   [2];
    logic       fs   [2];
    logic [3:0] comp [2];

    int checks = 0;
    int errors = 0;
    int t = 0;
    int ec0 = 4;
    int ec1 = 4;

    always #5 clk = ~clk;

    composite_timing_gen #(
        .DAC_WIDTH(4), .CLKS_PER_LINE(20), .H_SYNC_CLKS(3),
        .H_BACK_CLKS(4), .H_ACTIVE_CLKS(10), .LINES_PER_FIELD(8),
        .V_SYNC_LINES(2), .V_ACTIVE_START(3), .V_ACTIVE_LINES(4),
        .INTERLACE(0), .SYNC_LEVEL(0), .BLANK_LEVEL(4), .BLACK_LEVEL(5)
    ) dut0 (
        .clk(clk), .NRST(NRST), .en(en), .pix_data(pix_data),
        .pix_req(pr[0]), .hcount(hc[0]), .vcount(vc[0]), .field(fld[0]),
        .line_start(ls[0]), .field_start(fs[0]), .composite(comp[0])
    );

    composite_timing_gen #(
        .DAC_WIDTH(4), .CLKS_PER_LINE(20), .H_SYNC_CLKS(3),
        .H_BACK_CLKS(4), .H_ACTIVE_CLKS(10), .LINES_PER_FIELD(8),
        .V_SYNC_LINES(2), .V_ACTIVE_START(3), .V_ACTIVE_LINES(4),
        .INTERLACE(1), .SYNC_LEVEL(0), .BLANK_LEVEL(4), .BLACK_LEVEL(5)
    ) dut1 (
        .clk(clk), .NRST(NRST), .en(en), .pix_data(pix_data),
        .pix_req(pr[1]), .hcount(hc[1]), .vcount(vc[1]), .field(fld[1]),
        .line_start(ls[1]), .field_start(fs[1]), .composite(comp[1])
    );

    // Position after tt enabled clocks: progressive frame is 8 lines,
    // interlaced frame is 8 + 9 lines.
    function automatic void pos(input int tt, input int il,
                                output int h, output int v, output int f);
        int line;
        int p;
        line = tt / 20;
        h = tt % 20;
        if (il == 0) begin
            v = line % 8;
            f = 0;
        end else begin
            p = line % 17;
            v = (p < 8) ? p : p - 8;
            f = (p < 8) ? 0 : 1;
        end
    endfunction

    function automatic bit act(input int h, input int v);
        return (v >= 3) && (v < 7) && (h >= 7) && (h < 17);
    endfunction

    function automatic int lvl(input int h, input int v, input int pix);
        if (v < 2) return (h < 17) ? 0 : 4;
        if (h < 3) return 0;
        if (act(h, v)) return (5 + pix > 15) ? 15 : 5 + pix;
        return 4;
    endfunction

    task automatic tick(input int pix);
        int h, v, f, n0, n1;
        pix_data = 4'(pix);
        n0 = 4;
        n1 = 4;
        if (en) begin
            pos(t, 0, h, v, f);
            n0 = lvl(h, v, pix);
            pos(t, 1, h, v, f);
            n1 = lvl(h, v, pix);
        end
        @(posedge clk);
        #1;
        if (en) t++;
        ec0 = n0;
        ec1 = n1;
    endtask

    task automatic go_to(input int th, input int tv, output bit ok);
        int h, v, f;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            pos(t, 0, h, v, f);
            if (h == th && v == tv) begin
                ok = 1'b1;
                break;
            end
            tick(int'($urandom_range(0, 15)));
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        NRST = 1'b1;
        t = 0;
        ec0 = 4;
        ec1 = 4;
    endtask

    task automatic test_reset();
        en = 1'b1;
        NRST = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (hc[i] !== 5'd0 || vc[i] !== 4'd0 || fld[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_cnt dut%0d: h=%0d v=%0d f=%0b want 0/0/0",
                         i, hc[i], vc[i], fld[i]);
            end
            checks++;
            if (comp[i] !== 4'd4) begin
                errors++;
                $display("FAIL reset_comp dut%0d: got %0d want 4", i, comp[i]);
            end
            checks++;
            if (pr[i] !== 1'b0 || ls[i] !== 1'b0 || fs[i] !== 1'b0) begin
                errors++;
                $display("FAIL reset_strobe dut%0d: req=%0b ls=%0b fs=%0b want 0",
                         i, pr[i], ls[i], fs[i]);
            end
        end
        release_reset();
        tick(0);
        checks++;
        if (hc[0] !== 5'd1 || vc[0] !== 4'd0) begin
            errors++;
            $display("FAIL first_edge: h=%0d v=%0d want 1/0", hc[0], vc[0]);
        end
    endtask

    task automatic test_random_run();
        int h, v, f, ec, cyc;
        int last_fs [2];
        bit seen8 [2];
        int prev_f;
        last_fs[0] = -1;
        last_fs[1] = -1;
        seen8[0] = 1'b0;
        seen8[1] = 1'b0;
        prev_f = 0;
        en = 1'b1;
        for (cyc = 0; cyc < 7000; cyc++) begin
            for (int i = 0; i < 2; i++) begin
                pos(t, i, h, v, f);
                ec = (i == 0) ? ec0 : ec1;
                checks++;
                if (hc[i] !== 5'(h) || vc[i] !== 4'(v) || fld[i] !== 1'(f)) begin
                    errors++;
                    $display("FAIL pos dut%0d: h=%0d v=%0d f=%0b want %0d/%0d/%0d",
                             i, hc[i], vc[i], fld[i], h, v, f);
                end
                checks++;
                if (pr[i] !== act(h, v)) begin
                    errors++;
                    $display("FAIL pix_req dut%0d h=%0d v=%0d: got %0b want %0b",
                             i, h, v, pr[i], act(h, v));
                end
                checks++;
                if (ls[i] !== (h == 0) || fs[i] !== (h == 0 && v == 0)) begin
                    errors++;
                    $display("FAIL strobes dut%0d h=%0d v=%0d: ls=%0b fs=%0b",
                             i, h, v, ls[i], fs[i]);
                end
                checks++;
                if (comp[i] !== 4'(ec)) begin
                    errors++;
                    $display("FAIL composite dut%0d h=%0d v=%0d: got %0d want %0d",
                             i, h, v, comp[i], ec);
                end
                if (vc[i] === 4'd8) seen8[i] = 1'b1;
                if (fs[i] === 1'b1) begin
                    if (last_fs[i] >= 0) begin
                        checks++;
                        if (cyc - last_fs[i] !== ((i == 1 && f == 0) ? 180 : 160)) begin
                            errors++;
                            $display("FAIL fs_spacing dut%0d: got %0d want %0d", i,
                                     cyc - last_fs[i], (i == 1 && f == 0) ? 180 : 160);
                        end
                        if (i == 1) begin
                            checks++;
                            if (int'(fld[1]) == prev_f) begin
                                errors++;
                                $display("FAIL field_toggle: got %0b want %0d",
                                         fld[1], 1 - prev_f);
                            end
                        end
                    end
                    if (i == 1) prev_f = int'(fld[1]);
                    last_fs[i] = cyc;
                end
            end
            tick(int'($urandom_range(0, 15)));
        end
        checks++;
        if (seen8[0] !== 1'b0 || seen8[1] !== 1'b1) begin
            errors++;
            $display("FAIL vcount8: prog=%0b intl=%0b want 0/1", seen8[0], seen8[1]);
        end
    endtask

    task automatic test_vsync_lines();
        bit ok;
        int h;
        go_to(0, 0, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL vsync_goto: timeout got 0 want 1");
        end
        for (int k = 0; k < 40; k++) begin
            h = k % 20;
            checks++;
            if (pr[0] !== 1'b0) begin
                errors++;
                $display("FAIL vsync_req k=%0d: got %0b want 0", k, pr[0]);
            end
            tick(int'($urandom_range(0, 15)));
            checks++;
            if (comp[0] !== ((h < 17) ? 4'd0 : 4'd4)) begin
                errors++;
                $display("FAIL vsync_comp h=%0d: got %0d want %0d",
                         h, comp[0], (h < 17) ? 0 : 4);
            end
        end
    endtask

    task automatic test_line3();
        bit ok;
        int pix, want;
        bit inw;
        go_to(0, 3, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL line3_goto: timeout got 0 want 1");
        end
        for (int h = 0; h < 20; h++) begin
            inw = (h >= 7 && h <= 16);
            pix = inw ? h - 7 : int'($urandom_range(0, 15));
            checks++;
            if (pr[0] !== inw || hc[0] !== 5'(h)) begin
                errors++;
                $display("FAIL line3_req h=%0d: req=%0b hc=%0d want %0b", h,
                         pr[0], hc[0], inw);
            end
            tick(pix);
            want = inw ? h - 2 : ((h < 3) ? 0 : 4);
            checks++;
            if (comp[0] !== 4'(want)) begin
                errors++;
                $display("FAIL line3_comp h=%0d: got %0d want %0d", h, comp[0], want);
            end
        end
    endtask

    task automatic test_saturation();
        bit ok;
        int pixv [4];
        int want [4];
        pixv = '{15, 0, 11, 10};
        want = '{15, 5, 15, 15};
        go_to(10, 4, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL sat_goto: timeout got 0 want 1");
        end
        for (int k = 0; k < 4; k++) begin
            tick(pixv[k]);
            checks++;
            if (comp[0] !== 4'(want[k])) begin
                errors++;
                $display("FAIL saturate pix=%0d: got %0d want %0d",
                         pixv[k], comp[0], want[k]);
            end
        end
    endtask

    task automatic test_en_hold();
        bit ok;
        go_to(9, 4, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL hold_goto: timeout got 0 want 1");
        end
        en = 1'b0;
        #1;
        checks++;
        if (pr[0] !== 1'b0) begin
            errors++;
            $display("FAIL hold_req_now: got %0b want 0", pr[0]);
        end
        for (int k = 0; k < 5; k++) begin
            tick(int'($urandom_range(0, 15)));
            checks++;
            if (hc[0] !== 5'd9 || vc[0] !== 4'd4 || pr[0] !== 1'b0 ||
                comp[0] !== 4'd4 || ls[0] !== 1'b0) begin
                errors++;
                $display("FAIL hold k=%0d: h=%0d v=%0d req=%0b comp=%0d want 9/4/0/4",
                         k, hc[0], vc[0], pr[0], comp[0]);
            end
        end
        en = 1'b1;
        #1;
        checks++;
        if (pr[0] !== 1'b1) begin
            errors++;
            $display("FAIL resume_req: got %0b want 1", pr[0]);
        end
        tick(3);
        checks++;
        if (hc[0] !== 5'd10 || vc[0] !== 4'd4 || comp[0] !== 4'd8) begin
            errors++;
            $display("FAIL resume: h=%0d v=%0d comp=%0d want 10/4/8",
                     hc[0], vc[0], comp[0]);
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        go_to(5, 5, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL rstmid_goto: timeout got 0 want 1");
        end
        #2;
        NRST = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (hc[i] !== 5'd0 || vc[i] !== 4'd0 || fld[i] !== 1'b0 ||
                comp[i] !== 4'd4 || ls[i] !== 1'b0 || fs[i] !== 1'b0 ||
                pr[i] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset dut%0d: h=%0d v=%0d f=%0b comp=%0d ls=%0b fs=%0b want zeros/comp 4",
                         i, hc[i], vc[i], fld[i], comp[i], ls[i], fs[i]);
            end
        end
        release_reset();
        tick(0);
        checks++;
        if (hc[0] !== 5'd1 || comp[0] !== 4'd0) begin
            errors++;
            $display("FAIL post_reset: h=%0d comp=%0d want 1/0", hc[0], comp[0]);
        end
    endtask

    initial begin
        test_reset();
        test_random_run();
        test_vsync_lines();
        test_line3();
        test_saturation();
        test_en_hold();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
